// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - operand load and per-element MAC sequencer for the matrix-multiply datapath
module matmul_sequencer #(
  parameter int ROWS    = 3,
  parameter int COLS    = 3,
  parameter int INNER   = 4,
  parameter int MAC_LAT = 1,
  parameter int SEL_W   = 4,
  parameter int LD_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ld_en,
  output logic [LD_W-1:0]  ld_sel,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [SEL_W-1:0] a_sel,
  output logic [SEL_W-1:0] b_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_row,
  output logic [1:0]       out_col
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_ACCUM, S_DRAIN, S_OUTPUT, S_DONE
  } state_t;

  localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(ROWS*INNER + INNER*COLS - 1);
  localparam logic [SEL_W-1:0] K_LAST   = SEL_W'(INNER - 1);
  localparam logic [7:0]       D_LAST   = 8'(MAC_LAT - 1);
  localparam logic [1:0]       ROW_LAST = 2'(ROWS - 1);
  localparam logic [1:0]       COL_LAST = 2'(COLS - 1);

  state_t           state_q, state_d;
  logic [LD_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [1:0]       i_q, i_d, j_q, j_d;
  logic [SEL_W-1:0] k_q, k_d;
  logic [7:0]       dcnt_q, dcnt_d;
  logic             busy_q, busy_d, done_q, done_d, ld_en_q, ld_en_d;
  logic             mac_clr_q, mac_clr_d, mac_en_q, mac_en_d, out_valid_q, out_valid_d;
  logic [SEL_W-1:0] a_sel_q, a_sel_d, b_sel_q, b_sel_d;

  // Counters point at the element being produced; the load counter doubles as ld_sel.
  assign ld_sel    = ld_cnt_q;
  assign out_row   = i_q;
  assign out_col   = j_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ld_en     = ld_en_q;
  assign mac_clr   = mac_clr_q;
  assign mac_en    = mac_en_q;
  assign a_sel     = a_sel_q;
  assign b_sel     = b_sel_q;
  assign out_valid = out_valid_q;

  // Next state and counters, then outputs decoded from the next state so they leave on flops.
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    dcnt_d   = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          ld_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (ld_cnt_q == LD_LAST) begin
          state_d  = S_CLEAR;
          ld_cnt_d = '0;
          i_d      = '0;
          j_d      = '0;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      S_CLEAR: begin
        state_d = S_ACCUM;
        k_d     = '0;
      end
      S_ACCUM: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == D_LAST) begin
          state_d = S_OUTPUT;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          if (j_q < COL_LAST) begin
            j_d     = j_q + 1'b1;
            state_d = S_CLEAR;
          end else if (i_q < ROW_LAST) begin
            j_d     = '0;
            i_d     = i_q + 1'b1;
            state_d = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    ld_en_d     = (state_d == S_LOAD);
    mac_clr_d   = (state_d == S_CLEAR);
    mac_en_d    = (state_d == S_ACCUM);
    out_valid_d = (state_d == S_OUTPUT);
    a_sel_d     = a_sel_q;
    b_sel_d     = b_sel_q;
    if (state_d == S_ACCUM) begin
      a_sel_d = SEL_W'(i_d) * SEL_W'(INNER) + k_d;
      b_sel_d = k_d * SEL_W'(COLS) + SEL_W'(j_d);
    end
  end

  // State, counters and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ld_cnt_q    <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      dcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ld_en_q     <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      a_sel_q     <= '0;
      b_sel_q     <= '0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      dcnt_q      <= dcnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ld_en_q     <= ld_en_d;
      mac_clr_q   <= mac_clr_d;
      mac_en_q    <= mac_en_d;
      out_valid_q <= out_valid_d;
      a_sel_q     <= a_sel_d;
      b_sel_q     <= b_sel_d;
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - self-checking bench for matmul_sequencer
module tb_matmul_sequencer;

  logic       clk;
  logic       reset;
  logic       start, start2;
  logic       out_ready, ready2;
  logic       busy, done, ld_en, mac_clr, mac_en, out_valid;
  logic [4:0] ld_sel;
  logic [3:0] a_sel, b_sel;
  logic [1:0] out_row, out_col;
  logic       busy2, done2, ld_en2, mac_clr2, mac_en2, out_valid2;
  logic [4:0] ld_sel2;
  logic [3:0] a_sel2, b_sel2;
  logic [1:0] out_row2, out_col2;

  int n_total = 0;
  int n_pass  = 0;

  matmul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .ld_en(ld_en), .ld_sel(ld_sel), .mac_clr(mac_clr), .mac_en(mac_en),
    .a_sel(a_sel), .b_sel(b_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col)
  );

  matmul_sequencer #(.MAC_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .ld_en(ld_en2), .ld_sel(ld_sel2), .mac_clr(mac_clr2), .mac_en(mac_en2),
    .a_sel(a_sel2), .b_sel(b_sel2), .out_valid(out_valid2), .out_ready(ready2),
    .out_row(out_row2), .out_col(out_col2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       row;
    logic [1:0]       col;
    logic [3:0][3:0]  a;
    logic [3:0][3:0]  b;
    int               stall;
  } el_t;

  el_t tbl [9];

  localparam logic [5:0] F_IDLE  = 6'b000000;
  localparam logic [5:0] F_LOAD  = 6'b101000;
  localparam logic [5:0] F_CLR   = 6'b100100;
  localparam logic [5:0] F_ACC   = 6'b100010;
  localparam logic [5:0] F_DRAIN = 6'b100000;
  localparam logic [5:0] F_OUT   = 6'b100001;
  localparam logic [5:0] F_DONE  = 6'b110000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [5:0] flags();
    return {busy, done, ld_en, mac_clr, mac_en, out_valid};
  endfunction

  function automatic logic [5:0] flags2();
    return {busy2, done2, ld_en2, mac_clr2, mac_en2, out_valid2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_full(input bit use_stall, input bit poke_start);
    int st;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 24; c++) begin
      chk($sformatf("load_flags[%0d]", c), flags(), F_LOAD);
      chk($sformatf("ld_sel[%0d]", c), ld_sel, c);
      if (poke_start && c == 3) start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int e = 0; e < 9; e++) begin
      chk($sformatf("clr_flags[%0d]", e), flags(), F_CLR);
      step();
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("acc_flags[%0d.%0d]", e, k), flags(), F_ACC);
        chk($sformatf("a_sel[%0d.%0d]", e, k), a_sel, tbl[e].a[k]);
        chk($sformatf("b_sel[%0d.%0d]", e, k), b_sel, tbl[e].b[k]);
        step();
      end
      chk($sformatf("drain_flags[%0d]", e), flags(), F_DRAIN);
      step();
      st = use_stall ? tbl[e].stall : 0;
      for (int s = 0; s <= st; s++) begin
        chk($sformatf("out_flags[%0d.%0d]", e, s), flags(), F_OUT);
        chk($sformatf("out_row[%0d.%0d]", e, s), out_row, tbl[e].row);
        chk($sformatf("out_col[%0d.%0d]", e, s), out_col, tbl[e].col);
        out_ready = (s == st);
        if (poke_start) start = 1'b1;
        step();
        start = 1'b0;
      end
      out_ready = 1'b1;
    end
    chk("done_flags", flags(), F_DONE);
    step();
    chk("after_done_flags", flags(), F_IDLE);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("idle_hold[%0d]", c), flags(), F_IDLE);
    end
  endtask

  initial begin
    int dn, cyc, drn;
    tbl[0] = '{row:2'd0, col:2'd0, a:{4'd3, 4'd2, 4'd1, 4'd0},   b:{4'd9, 4'd6, 4'd3, 4'd0},  stall:5};
    tbl[1] = '{row:2'd0, col:2'd1, a:{4'd3, 4'd2, 4'd1, 4'd0},   b:{4'd10, 4'd7, 4'd4, 4'd1}, stall:0};
    tbl[2] = '{row:2'd0, col:2'd2, a:{4'd3, 4'd2, 4'd1, 4'd0},   b:{4'd11, 4'd8, 4'd5, 4'd2}, stall:0};
    tbl[3] = '{row:2'd1, col:2'd0, a:{4'd7, 4'd6, 4'd5, 4'd4},   b:{4'd9, 4'd6, 4'd3, 4'd0},  stall:0};
    tbl[4] = '{row:2'd1, col:2'd1, a:{4'd7, 4'd6, 4'd5, 4'd4},   b:{4'd10, 4'd7, 4'd4, 4'd1}, stall:2};
    tbl[5] = '{row:2'd1, col:2'd2, a:{4'd7, 4'd6, 4'd5, 4'd4},   b:{4'd11, 4'd8, 4'd5, 4'd2}, stall:0};
    tbl[6] = '{row:2'd2, col:2'd0, a:{4'd11, 4'd10, 4'd9, 4'd8}, b:{4'd9, 4'd6, 4'd3, 4'd0},  stall:0};
    tbl[7] = '{row:2'd2, col:2'd1, a:{4'd11, 4'd10, 4'd9, 4'd8}, b:{4'd10, 4'd7, 4'd4, 4'd1}, stall:0};
    tbl[8] = '{row:2'd2, col:2'd2, a:{4'd11, 4'd10, 4'd9, 4'd8}, b:{4'd11, 4'd8, 4'd5, 4'd2}, stall:1};

    reset = 1'b0; start = 1'b0; start2 = 1'b0; out_ready = 1'b1; ready2 = 1'b1;
    step();
    step();
    chk("rst_flags", flags(), F_IDLE);
    chk("rst_ld_sel", ld_sel, 0);
    chk("rst_a_sel", a_sel, 0);
    chk("rst_b_sel", b_sel, 0);
    chk("rst_row_col", {out_row, out_col}, 0);
    reset = 1'b1;
    step();

    run_full(1'b0, 1'b0);
    run_full(1'b1, 1'b1);

    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 10; c++) step();
    chk("pre_reset_ld_sel", ld_sel, 10);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_flags", flags(), F_IDLE);
    chk("async_rst_ld_sel", ld_sel, 0);
    step();
    reset = 1'b1;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (done || busy) dn++;
    end
    chk("no_activity_after_reset", dn, 0);

    start2 = 1'b1;
    step();
    start2 = 1'b0;
    cyc = 0; dn = 0; drn = 0;
    while (busy2 && cyc < 1000) begin
      cyc++;
      if (done2) dn++;
      if (flags2() == F_DRAIN) drn++;
      step();
    end
    chk("lat3_busy_cycles", cyc, 106);
    chk("lat3_done_count", dn, 1);
    chk("lat3_drain_cycles", drn, 27);
    chk("lat3_idle_flags", flags2(), F_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Top-level sequencer for the matrix-multiply datapath. Loads operand registers, then walks every result element (i,j). For each element it clears the MAC, accumulates INNER products, waits out the MAC latency and hands the result downstream with a valid/ready handshake. Replaces hand-enumerated per-state select decoding with row/column/inner counters.

Parameters:
ROWS, 3, rows of A and of result C
COLS, 3, columns of B and of C
INNER, 4, columns of A / rows of B (accumulation length)
MAC_LAT, 1, cycles from last mac_en to MAC result stable (>=1)
SEL_W, 4, width of a_sel/b_sel; must hold max(ROWS*INNER, INNER*COLS)-1
LD_W, 5, width of ld_sel; must hold ROWS*INNER+INNER*COLS-1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a multiply; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last result is accepted
ld_en  out  1  operand register load enable
ld_sel  out  LD_W  operand register index being loaded; A first (0..ROWS*INNER-1), then B
mac_clr  out  1  synchronous clear of the MAC accumulator
mac_en  out  1  MAC accumulate enable
a_sel  out  SEL_W  A operand index = i*INNER+k
b_sel  out  SEL_W  B operand index = k*COLS+j
out_valid  out  1  MAC result is valid for element (out_row,out_col)
out_ready  in  1  downstream accepts result
out_row  out  2  i of presented result
out_col  out  2  j of presented result

Behaviour:
- Single clock domain. All outputs are registered, and all state/counters are flops. Reset low forces the flops immediately, independent of clk.
- Reset values: state=IDLE, i=j=k=0, load counter=0, busy=0, done=0, ld_en=0, ld_sel=0, mac_clr=0, mac_en=0, a_sel=0, b_sel=0, out_valid=0, out_row=0, out_col=0.
- Reset asserted mid-operation: the run is abandoned and the block returns to the reset values. No done pulse is produced. A new start is required.
- IDLE: start=1 -> LOAD with load counter=0. Otherwise stay.
- LOAD: ld_en=1, ld_sel=load counter. Lasts exactly ROWS*INNER+INNER*COLS cycles (24 at defaults). After the last index, go to CLEAR with i=j=0.
- CLEAR: mac_clr=1 for one cycle, k=0, then go to ACCUM.
- ACCUM: mac_en=1 for exactly INNER cycles (k=0..INNER-1), with a_sel/b_sel per formulas on the same cycle. After k=INNER-1, go to DRAIN.
- DRAIN: mac_en=0 for MAC_LAT cycles, then go to OUTPUT.
- OUTPUT: out_valid=1, out_row=i, out_col=j, held stable until out_ready=1. The transfer completes on the cycle where out_valid&&out_ready. Then:
  - if j<COLS-1: j+1, go to CLEAR;
  - else if i<ROWS-1: j=0, i+1, go to CLEAR;
  - else go to DONE.
- out_ready is ignored outside OUTPUT. out_valid never drops without a transfer.
- DONE: done=1 for one cycle, busy=1, then go to IDLE with done=0.
- start while busy=1 is ignored; no queuing. start held high across DONE->IDLE starts a new run on the first IDLE cycle.
- mac_clr and mac_en are never high on the same cycle. ld_en is never high outside LOAD.
- a_sel/b_sel hold their last value outside ACCUM.
- Counter arithmetic is unsigned. Wrap is never reached because the FSM bounds every counter.

Test Plan:
- Reset mid-LOAD: assert reset at ld_sel=10 -> all outputs 0 asynchronously, state IDLE, and no done after release.
- Full run, defaults, out_ready tied 1: start pulse -> 24 ld_en cycles, ld_sel 0..23, then 9 elements of 7 cycles each (1 clr + 4 en + 1 drain + 1 out). done pulses once, busy falls the following cycle.
- Index check, element (1,2): during ACCUM, a_sel = 4,5,6,7 and b_sel = 2,5,8,11. Then out_row=1 and out_col=2 with out_valid.
- Backpressure: out_ready=0 for 5 cycles at element (0,0) -> out_valid/out_row/out_col held stable for 5 cycles, mac_clr stays 0, and the sequence resumes after out_ready=1.
- start asserted at ld_sel=3 and again during OUTPUT -> no effect. Exactly one done per run.
- MAC_LAT=3 build: DRAIN lasts 3 cycles before each out_valid. With out_ready=1, total run = 24 + 9*(1+4+3+1) + 1 done cycle.
